// File: rtl/linear_interp_upsampler.sv
// Linear-interpolation upsampler by L = 2**INTERP_LOG2. Each accepted input pair
// (prev, curr) produces L outputs stepping from prev toward curr with floor rounding.
module linear_interp_upsampler #(
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned INTERP_LOG2 = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_first
);

   localparam int unsigned DIFF_W = DATA_WIDTH + 1;
   localparam int unsigned PROD_W = DATA_WIDTH + 1 + INTERP_LOG2;

   typedef enum logic [1:0] {IDLE, PRIME, RUN, NEXT} state_t;

   state_t                   state_q, state_d;
   logic [DATA_WIDTH-1:0]    prev_q, prev_d;
   logic [DATA_WIDTH-1:0]    curr_q, curr_d;
   logic [DATA_WIDTH-1:0]    out_data_q, out_data_d;
   logic [INTERP_LOG2-1:0]   k_q, k_d;
   logic                     out_valid_q, out_valid_d;
   logic                     out_first_q, out_first_d;
   logic                     in_ready_q, in_ready_d;

   logic signed [DIFF_W-1:0] diff_c;
   logic signed [PROD_W-1:0] diff_ext_c;
   logic signed [PROD_W-1:0] k_ext_c;
   logic signed [PROD_W-1:0] prod_c;
   logic signed [PROD_W-1:0] step_c;
   logic [DATA_WIDTH-1:0]    interp_c;
   logic                     in_xfer_c;
   logic                     slot_free_c;

   // Interpolated sample for the current phase; result always lies between prev and curr
   always_comb begin
      diff_c     = $signed({curr_q[DATA_WIDTH-1], curr_q}) - $signed({prev_q[DATA_WIDTH-1], prev_q});
      diff_ext_c = PROD_W'(diff_c);
      k_ext_c    = $signed(PROD_W'(k_q));
      prod_c     = diff_ext_c * k_ext_c;
      step_c     = prod_c >>> INTERP_LOG2;
      interp_c   = prev_q + step_c[DATA_WIDTH-1:0];
   end

   always_comb begin
      state_d     = state_q;
      prev_d      = prev_q;
      curr_d      = curr_q;
      out_data_d  = out_data_q;
      k_d         = k_q;
      out_valid_d = out_valid_q;
      out_first_d = out_first_q;
      in_xfer_c   = in_valid && in_ready_q;
      slot_free_c = !out_valid_q || out_ready;

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
         out_first_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (in_xfer_c) begin
               curr_d  = in_data;
               state_d = PRIME;
            end
         end
         PRIME, NEXT: begin
            if (in_xfer_c) begin
               prev_d  = curr_q;
               curr_d  = in_data;
               k_d     = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (slot_free_c) begin
               out_data_d  = interp_c;
               out_valid_d = 1'b1;
               out_first_d = (k_q == '0);
               k_d         = k_q + INTERP_LOG2'(1);
               if (k_q == '1) begin
                  state_d = NEXT;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Registered so the handshake never sees a path from out_ready or in_valid
      in_ready_d = (state_d != RUN);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         prev_q      <= '0;
         curr_q      <= '0;
         out_data_q  <= '0;
         k_q         <= '0;
         out_valid_q <= 1'b0;
         out_first_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         prev_q      <= prev_d;
         curr_q      <= curr_d;
         out_data_q  <= out_data_d;
         k_q         <= k_d;
         out_valid_q <= out_valid_d;
         out_first_q <= out_first_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_first = out_first_q;

endmodule
